// File: rtl/ft_tx_scheduler_pkg.sv
// Shared types and header-word helper for the FT600 transmit scheduler.
// FT_TX_HDR_EN (defined at build time) enables the per-grant header word.
package ft_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    BURST = 2'd2
  } ft_tx_state_t;

  localparam logic [7:0] FT_TX_HDR_MAGIC = 8'hA5;

  function automatic logic [15:0] ft_tx_hdr(input logic [3:0] id);
    return {FT_TX_HDR_MAGIC, 4'h0, id};
  endfunction

endpackage

// File: rtl/ft_tx_scheduler_if.sv
// Requester-side streams plus the FT600 write-block port, bundled for the scheduler.
interface ft_tx_scheduler_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0][15:0] src_data;
  logic [NUM_SRC-1:0][1:0]  src_be;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC-1:0]       src_last;
  logic [NUM_SRC-1:0]       src_ready;
  logic [15:0]              din;
  logic [1:0]               din_valid;
  logic                     full;
  logic                     rst_busy;

  modport slave (
    input  src_data, src_be, src_valid, src_last, full, rst_busy,
    output src_ready, din, din_valid
  );

  modport master (
    output src_data, src_be, src_valid, src_last, full, rst_busy,
    input  src_ready, din, din_valid
  );
endinterface

// File: rtl/ft_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit scanning upward from ptr+1.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_id,
  output logic         gnt_any
);
  int idx;

  // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = W'(idx);
      end
    end
  end
endmodule

// File: rtl/ft_tx_scheduler.sv
// Round-robin burst scheduler sharing the FT600 TX FIFO write port among NUM_SRC streams.
// Optional header word per grant when FT_TX_HDR_EN is defined.
module ft_tx_scheduler
  import ft_tx_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int MAX_BURST = 64,
  localparam int GW = $clog2(NUM_SRC),
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  ft_tx_scheduler_if.slave    bus,
  output logic [GW-1:0]       grant_id,
  output logic                busy
);
  ft_tx_state_t  r_state, w_state_nxt;
  logic [GW-1:0] r_grant, w_grant_nxt;
  logic [GW-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [GW-1:0] w_arb_id;
  logic          w_arb_any;
  logic          w_wr_ok;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .req     (bus.src_valid),
    .ptr     (r_rr_ptr),
    .gnt_id  (w_arb_id),
    .gnt_any (w_arb_any)
  );

  assign w_wr_ok   = !bus.full && !bus.rst_busy;
  assign w_cnt_inc = r_cnt + CW'(1);
  assign grant_id  = r_grant;
  assign busy      = (r_state != IDLE);

  // Outputs depend only on registered state plus valid/full/rst_busy, so a
  // write is killed in the same cycle full rises.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_cnt_nxt     = r_cnt;
    bus.din       = bus.src_data[r_grant];
    bus.din_valid = 2'b00;
    bus.src_ready = '0;
    case (r_state)
      IDLE: begin
        if (w_arb_any) begin
          w_grant_nxt = w_arb_id;
`ifdef FT_TX_HDR_EN
          w_state_nxt = HDR;
`else
          w_state_nxt = BURST;
`endif
        end
      end
`ifdef FT_TX_HDR_EN
      HDR: begin
        if (w_wr_ok) begin
          bus.din       = ft_tx_hdr(4'(r_grant));
          bus.din_valid = 2'b11;
          w_state_nxt   = BURST;
        end
      end
`endif
      BURST: begin
        if (bus.src_valid[r_grant] && w_wr_ok) begin
          bus.din_valid          = bus.src_be[r_grant];
          bus.src_ready[r_grant] = 1'b1;
          if (bus.src_last[r_grant] || (w_cnt_inc == CW'(MAX_BURST))) begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = r_grant;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pointer resets to the last source so source 0 wins the first scan.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= GW'(NUM_SRC - 1);
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end
endmodule

// File: doc/ft_tx_scheduler.md
# ft_tx_scheduler

Round-robin scheduler that shares the single FT600 transmit FIFO write port among `NUM_SRC` independent 16-bit streaming requesters. It sits between the user-side producers and the FT600 write block's `din`/`din_valid`/`full`/`rst_busy` interface, all in the `clk` domain. Each grant is a burst bounded by a source `last` marker or `MAX_BURST` words, optionally preceded by a header word. No word is ever written while the FIFO is full or in reset.

## Interface
Parameters:
- `NUM_SRC`, 4: number of requesters, legal range 2..16.
- `MAX_BURST`, 64: maximum payload words per grant, legal range 1..65535.

Ports:
- `clk`  in  1  system clock; also the FT600 FIFO write clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `src_data`  in  NUM_SRC×16  payload word per source.
- `src_be`  in  NUM_SRC×2  byte enables per source; `2'b00` is illegal while valid.
- `src_valid`  in  NUM_SRC  source has a word.
- `src_last`  in  NUM_SRC  word is the final word of the packet.
- `src_ready`  out  NUM_SRC  word accepted this cycle.
- `din`  out  16  to the FT600 write block.
- `din_valid`  out  2  byte enables to the FT600 write block; non-zero means write.
- `full`  in  1  FIFO full, from the FT600 write block.
- `rst_busy`  in  1  FIFO reset busy, from the FT600 write block.
- `grant_id`  out  $clog2(NUM_SRC)  current or most recent grantee.
- `busy`  out  1  state is not IDLE.

## Operation
- Write enable: `wr_ok = !full && !rst_busy`. The scheduler issues no write and no `src_ready` when `wr_ok` is 0.
- States:
  - IDLE
    - Scan `src_valid` starting at `rr_ptr+1` (mod NUM_SRC) and latch the first requester into `grant`.
    - Next state is HDR if `FT_TX_HDR_EN` is defined, otherwise BURST.
    - With no requests, remain in IDLE.
  - HDR
    - While `wr_ok`: drive `din = {8'hA5, 4'h0, grant[3:0]}` and `din_valid = 2'b11`, then go to BURST.
    - Otherwise hold in HDR.
  - BURST
    - Drive `din = src_data[grant]`, `din_valid = src_valid[grant] && wr_ok ? src_be[grant] : 2'b00`, and `src_ready[grant]` equal to the same condition.
    - On each accepted word, increment `cnt`.
    - Leave BURST when the accepted word has `src_last`, or when `cnt` reaches `MAX_BURST`. On exit, set `rr_ptr = grant`, clear `cnt`, and go to IDLE.
    - A source that deasserts `src_valid` mid-burst keeps the grant. There is no timeout.
- `src_ready` is 0 for every non-granted source, in all states.
- Width rules:
  - `cnt` is $clog2(MAX_BURST+1) bits and never wraps.
  - `rr_ptr` wraps NUM_SRC-1 → 0.
- Reset (`rst_n`=0 at a clock edge), from any state including mid-burst:
  - state = IDLE, `cnt` = 0, `rr_ptr` = NUM_SRC-1 so source 0 wins first, `grant` = 0.
  - No partial-burst recovery.

## Timing
- `din`, `din_valid`, and `src_ready` are combinational from registered state/grant, `src_valid[grant]`, `full`, and `rst_busy`.
- This lets a write be suppressed in the same cycle `full` rises.
- The only combinational path from `full` to `din_valid` is through `wr_ok`.
- Latency from a request in IDLE to the first output write:
  - 1 cycle for the grant decision.
  - Plus 1 header cycle when the header is enabled.
- Each burst exit costs 1 IDLE cycle before the next grant.
- Back-to-back payload: 1 word per cycle while `wr_ok` and `src_valid` are both high.
- Reset values (all outputs):
  - `din_valid` = 0, `src_ready` = 0, `busy` = 0, `grant_id` = 0.
  - `din` = `src_data[0]`; it is don't-care while `din_valid` = 0.

## Configuration
- `FT_TX_HDR_EN` defined: the HDR state exists, and each grant emits the header word `16'hA5_0n` (n = source id) before its payload.
- Not defined: HDR state and header logic are removed, and IDLE goes directly to BURST.

## Structure
- Package `ft_tx_pkg`:
  - state enum `ft_tx_state_t` (IDLE, HDR, BURST)
  - `FT_TX_HDR_MAGIC` = 8'hA5
  - function building the header word from an id
- Sub-module `rr_arbiter`:
  - parameter N
  - inputs `req[N-1:0]` and `ptr`
  - outputs `gnt_id` and `gnt_any`, purely combinational
  - instantiated once

## Test plan
- NUM_SRC=4, header on; src0 sends 3 words 0x1111..0x3333 with `last` on the 3rd → `din` sequence A500, 1111, 2222, 3333, all with `din_valid`=11, then `busy` falls.
- src1 and src2 request continuously, 2-word packets each → grants alternate 1,2,1,2; no source is granted twice while the other waits.
- MAX_BURST=4; src3 streams 10 words with no `last` → bursts of 4, 4, 2. When src3 is the only requester, it is re-granted after each 1-cycle IDLE gap, and a header precedes each burst.
- `full` held 1 for 5 cycles mid-burst → `din_valid`=0 and `src_ready`=0 for exactly those cycles; no word lost or duplicated; the sequence resumes with the next word.
- `rst_busy`=1 during HDR → the header is held, then emitted the cycle after `rst_busy` falls.
- `rst_n` low for 1 cycle mid-burst on src2 → next cycle is IDLE with `din_valid`=0; with all sources requesting, src0 is granted next.
